// File: rtl/haeuslermarkus_fir_filter.sv
`default_nettype none
// ============================================================================
// Module      : haeuslermarkus_fir_filter
// Description : 4-tap FIR filter packaged as a TinyTapeout tile. The filter
//               takes unsigned 8-bit samples and run-time loadable 4-bit
//               unsigned coefficients. It produces an 11-bit saturated result.
// Revision    : 1.0 - initial release
// ============================================================================
module haeuslermarkus_fir_filter (
    input  logic       clk,
    input  logic       rst_n,    // active-high synchronous reset despite the name
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NTAPS = 4;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int OW    = 11;
    localparam int AW    = 14;   // widest possible sum of four 12-bit products

    localparam logic [AW-1:0] c_acc_max = AW'((1 << OW) - 1);
    localparam logic [OW-1:0] c_y_max   = '1;

    logic [CW-1:0] r_coef [NTAPS];
    logic [DW-1:0] r_x    [NTAPS-1];
    logic [OW-1:0] r_y;

    logic          w_set;
    logic          w_take;
    logic [AW-1:0] w_acc;
    logic [OW-1:0] w_y_sat;

    // The tile-select input and the spare uio bits have no function here.
    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in[5:0]};

    // A coefficient write wins over a sample that arrives in the same cycle.
    assign w_set  = uio_in[6];
    assign w_take = uio_in[7] & ~uio_in[6];

    // Full-width multiply-accumulate over the incoming sample and the delay line.
    always_comb begin
        w_acc = AW'(r_coef[0]) * AW'(ui_in);
        for (int k = 1; k < NTAPS; k++) begin
            w_acc = w_acc + AW'(r_coef[k]) * AW'(r_x[k-1]);
        end
    end

    // Clamp to the largest value the output can represent.
    assign w_y_sat = (w_acc > c_acc_max) ? c_y_max : w_acc[OW-1:0];

    // Coefficients, delay line and output register. Reset takes priority.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_coef[0] <= CW'(1);
            r_coef[1] <= CW'(2);
            r_coef[2] <= CW'(2);
            r_coef[3] <= CW'(1);
            for (int k = 0; k < NTAPS - 1; k++) begin
                r_x[k] <= '0;
            end
            r_y <= '0;
        end else if (w_set) begin
            r_coef[ui_in[5:4]] <= ui_in[3:0];
        end else if (w_take) begin
            r_y    <= w_y_sat;
            r_x[0] <= ui_in;
            for (int k = 1; k < NTAPS - 1; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    assign uo_out  = r_y[7:0];
    assign uio_out = {5'b0, r_y[OW-1:8]};
    assign uio_oe  = 8'b0011_1111;

endmodule
`default_nettype wire

// File: tb/tb_haeuslermarkus_fir_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_haeuslermarkus_fir_filter
// Description : Self-checking bench for the 4-tap FIR tile. It runs directed
//               scenarios with known results, then random traffic checked
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_haeuslermarkus_fir_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Reference model state: coefficients, sample history (newest first), output
    int m_c [4];
    int m_hist [$];
    int m_y;

    haeuslermarkus_fir_filter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_y();
        return {21'd0, uio_out[2:0], uo_out};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, written from the filter's arithmetic definition.
    task automatic model_edge(input logic r, input logic set, input logic vld, input logic [7:0] d);
        int acc;
        if (r) begin
            m_c = '{1, 2, 2, 1};
            m_hist = '{0, 0, 0};
            m_y = 0;
        end else if (set) begin
            m_c[(d >> 4) & 3] = d & 15;
        end else if (vld) begin
            acc = m_c[0] * d;
            for (int k = 0; k < 3; k++) acc += m_c[k+1] * m_hist[k];
            m_y = (acc > 2047) ? 2047 : acc;
            m_hist.push_front(int'(d));
            void'(m_hist.pop_back());
        end
    endtask

    // Drive one cycle, let the edge happen, then update the model.
    task automatic cyc(input logic r, input logic set, input logic vld, input logic [7:0] d,
                       input logic [5:0] spare = 6'd0);
        rst_n  = r;
        uio_in = {vld, set, spare};
        ui_in  = d;
        @(posedge clk);
        #1;
        model_edge(r, set, vld, d);
        rst_n  = 1'b0;
        uio_in = '0;
        ui_in  = '0;
    endtask

    initial begin
        int hold;
        logic [31:0] exp1 [5];
        logic [31:0] exp2 [4];
        int op;
        logic [7:0] d;
        m_hist = '{0, 0, 0};
        m_c = '{1, 2, 2, 1};
        m_y = 0;

        // Reset
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        check("reset_y", dut_y(), 0);
        check("reset_uio_out", {24'd0, uio_out}, 0);
        check("uio_oe", {24'd0, uio_oe}, 32'h3F);

        // 1: impulse response with default coefficients
        exp1 = '{100, 200, 200, 100, 0};
        cyc(0, 0, 1, 8'd100);
        check("impulse_0", dut_y(), exp1[0]);
        for (int i = 1; i < 5; i++) begin
            cyc(0, 0, 1, 8'd0);
            check($sformatf("impulse_%0d", i), dut_y(), exp1[i]);
        end

        // 2: step response
        cyc(1, 0, 0, 8'h00);
        exp2 = '{255, 765, 1275, 1530};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 8'd255);
            check($sformatf("step_%0d", i), dut_y(), exp2[i]);
        end

        // 3: coefficient writes hold y, then c={3,0,0,0}
        cyc(0, 1, 0, 8'h03); check("wr_hold_0", dut_y(), 1530);
        cyc(0, 1, 0, 8'h10); check("wr_hold_1", dut_y(), 1530);
        cyc(0, 1, 0, 8'h20); check("wr_hold_2", dut_y(), 1530);
        cyc(0, 1, 0, 8'h30); check("wr_hold_3", dut_y(), 1530);
        cyc(0, 0, 1, 8'd50); check("c3000_y", dut_y(), 150);

        // 4: all coefficients 15, saturation; ui_in[7:6] must be ignored
        cyc(0, 1, 0, 8'hCF);
        cyc(0, 1, 0, 8'h1F);
        cyc(0, 1, 0, 8'h6F);
        cyc(0, 1, 0, 8'h3F); check("wr15_hold", dut_y(), 150);
        cyc(0, 0, 1, 8'd255);
        check("sat_y", dut_y(), 2047);
        check("sat_uo_out", {24'd0, uo_out}, 32'hFF);
        check("sat_uio_out", {24'd0, uio_out}, 32'h07);

        // 5: set and valid together -> write only, no sample consumed
        cyc(0, 1, 1, 8'h05); check("setvalid_hold", dut_y(), 2047);
        hold = 2047;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 8'($urandom), 6'($urandom));
            check($sformatf("idle_%0d", i), dut_y(), hold);
        end
        cyc(0, 1, 0, 8'h11);
        cyc(0, 1, 0, 8'h20);
        cyc(0, 1, 0, 8'h30);
        // x0 must still be 255 (not 5) if the combined cycle consumed nothing
        cyc(0, 0, 1, 8'd0); check("delay_untouched", dut_y(), 255);
        cyc(0, 0, 1, 8'd2); check("c0_is_5", dut_y(), 10);

        // 6: mid-stream reset
        cyc(0, 0, 1, 8'd7);  check("pre_reset", dut_y(), 37);
        cyc(1, 0, 1, 8'd99); check("midreset_y", dut_y(), 0);
        cyc(0, 0, 1, 8'd10); check("post_reset", dut_y(), 10);
        cyc(0, 0, 1, 8'd0);  check("post_reset_c1", dut_y(), 20);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            op  = $urandom_range(0, 99);
            d   = 8'($urandom);
            ena = 1'($urandom);
            if (op < 3)       cyc(1, 1'($urandom), 1'($urandom), d, 6'($urandom));
            else if (op < 18) cyc(0, 1, 1'($urandom), d, 6'($urandom));
            else if (op < 75) cyc(0, 0, 1, d, 6'($urandom));
            else              cyc(0, 0, 0, d, 6'($urandom));
            check($sformatf("rand_%0d", i), dut_y(), 32'(m_y));
            check($sformatf("rand_hi_%0d", i), {24'd0, uio_out[7:3]}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
